// File: rtl/shift_rot_unit.sv
// Multi-cycle shift/rotate/swap unit: a work register is stepped up to STEP
// positions per BUSY cycle, and the result is held in DONE until it is consumed.
module shift_rot_unit #(
  parameter int WIDTH = 20,
  parameter int STEP  = 4,
  parameter int AMT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic [AMT_W-1:0] amount,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result_a,
  output logic [WIDTH-1:0] result_b,
  output logic             err,
  output logic             busy
);

  // One extra bit so that a count equal to WIDTH is always representable.
  localparam int CW = AMT_W + 1;
  localparam logic [CW-1:0] W_C    = CW'(WIDTH);
  localparam logic [CW-1:0] STEP_C = CW'(STEP);

  localparam logic [2:0] OP_SHR  = 3'b000;
  localparam logic [2:0] OP_SHL  = 3'b001;
  localparam logic [2:0] OP_ROR  = 3'b010;
  localparam logic [2:0] OP_ROL  = 3'b011;
  localparam logic [2:0] OP_SAR  = 3'b100;
  localparam logic [2:0] OP_SWAP = 3'b101;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] work_q;
  logic [WIDTH-1:0] b_q;
  logic [CW-1:0]    rem_q;
  logic             err_q;

  logic             accept;
  logic [CW-1:0]    amt_ext;
  logic [CW-1:0]    eff_d;
  logic [CW-1:0]    step_amt;
  logic [WIDTH-1:0] work_d;
  logic [WIDTH-1:0] b_d;
  logic             err_d;

  function automatic logic [WIDTH-1:0] step_fn(input logic [2:0] o,
                                               input logic [WIDTH-1:0] v,
                                               input logic [CW-1:0] s);
    logic [WIDTH-1:0] r;
    case (o)
      OP_SHR:  r = v >> s;
      OP_SHL:  r = v << s;
      OP_ROR:  r = (v >> s) | (v << (W_C - s));
      OP_ROL:  r = (v << s) | (v >> (W_C - s));
      OP_SAR:  r = $unsigned($signed(v) >>> s);
      default: r = v;
    endcase
    return r;
  endfunction

  assign in_ready  = (state_q == IDLE) || (state_q == DONE && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result_a  = work_q;
  assign result_b  = b_q;
  assign err       = err_q;

  always_comb begin
    amt_ext  = {1'b0, amount};
    eff_d    = '0;
    work_d   = data_a;
    b_d      = '0;
    err_d    = 1'b0;
    step_amt = (rem_q > STEP_C) ? STEP_C : rem_q;
    case (op)
      OP_SHR, OP_SHL, OP_SAR: eff_d = (amt_ext > W_C) ? W_C : amt_ext;
      OP_ROR, OP_ROL:         eff_d = amt_ext % W_C;
      OP_SWAP: begin
        work_d = data_b;
        b_d    = data_a;
      end
      default: begin
        work_d = '0;
        err_d  = 1'b1;
      end
    endcase
  end

  // Reset has priority over acceptance; acceptance covers both IDLE and DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      work_q  <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      op_q    <= op;
      work_q  <= work_d;
      b_q     <= b_d;
      rem_q   <= eff_d;
      err_q   <= err_d;
      state_q <= (eff_d == '0) ? DONE : BUSY;
    end else begin
      case (state_q)
        BUSY: begin
          work_q <= step_fn(op_q, work_q, step_amt);
          rem_q  <= rem_q - step_amt;
          if (rem_q == step_amt) state_q <= DONE;
        end
        DONE: if (out_ready) state_q <= IDLE;
        default: ;
      endcase
    end
  end

endmodule
